// File: rtl/fft_result_capture.sv
// Captures one frame of FFT output samples into a result RAM, optionally undoing
// the bit-reversed output order, and flags completion for the memory checker.
module fft_result_capture #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int BITREV = 1
) (
  input  logic                clk,
  input  logic                sclr,
  input  logic                arm,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   rd_address,
  output logic [DATA_W-1:0]   rd_data,
  output logic                start_comp,
  output logic [ADDR_W:0]     sample_count,
  output logic                busy,
  output logic                overflow
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                we;
  logic [ADDR_W-1:0]   idx, idx_rev, wa;
  logic [DATA_W-1:0]   mem_q [N];

  assign idx = cnt_q[ADDR_W-1:0];

  for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
    assign idx_rev[i] = idx[ADDR_W-1-i];
  end

  assign wa = (BITREV != 0) ? idx_rev : idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      CAPTURE: begin
        // A restart request discards any sample offered in the same cycle.
        if (arm) begin
          cnt_d = '0;
        end else if (in_valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          if (cnt_q == LAST) state_d = FULL;
        end
      end
      FULL: begin
        if (arm) begin
          state_d = CAPTURE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (in_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM contents survive sclr; only the frame bookkeeping is reset.
  always_ff @(posedge clk) begin
    if (we && !sclr) mem_q[wa] <= in_data;
  end

  assign rd_data      = mem_q[rd_address];
  assign in_ready     = (state_q == CAPTURE);
  assign busy         = (state_q == CAPTURE);
  assign start_comp   = (state_q == FULL);
  assign sample_count = cnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_fft_result_capture.sv
// Directed bench: a natural-order and a bit-reversed instance share one stimulus stream.
module tb_fft_result_capture;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int N = 32;

  logic              clk = 1'b0;
  logic              sclr, arm, in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] rd_address;
  logic              in_ready_n, start_comp_n, busy_n, overflow_n;
  logic              in_ready_r, start_comp_r, busy_r, overflow_r;
  logic [DATA_W-1:0] rd_data_n, rd_data_r;
  logic [ADDR_W:0]   cnt_n, cnt_r;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] ref_mem [N];
  logic q;

  always #5 clk = ~clk;

  fft_result_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BITREV(0)) dut_nat (
    .clk(clk), .sclr(sclr), .arm(arm), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_n), .rd_address(rd_address), .rd_data(rd_data_n),
    .start_comp(start_comp_n), .sample_count(cnt_n), .busy(busy_n), .overflow(overflow_n)
  );

  fft_result_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BITREV(1)) dut_rev (
    .clk(clk), .sclr(sclr), .arm(arm), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_r), .rd_address(rd_address), .rd_data(rd_data_r),
    .start_comp(start_comp_r), .sample_count(cnt_r), .busy(busy_r), .overflow(overflow_r)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_nat(input int a, output logic [DATA_W-1:0] d);
    rd_address = ADDR_W'(a);
    #1;
    d = rd_data_n;
  endtask

  // Checker model: wait for start_comp, sweep the address counter, AND the compares.
  task automatic mem_check(output logic qo);
    logic [DATA_W-1:0] d;
    int waited = 0;
    while (!start_comp_n && waited < 200) begin
      tick();
      waited++;
    end
    if (!start_comp_n) chk("chk_start_timeout", 64'(start_comp_n), 64'd1);
    qo = 1'b1;
    for (int a = 0; a < N; a++) begin
      read_nat(a, d);
      if (d !== ref_mem[a]) qo = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    sclr = 1'b1; arm = 1'b0; in_valid = 1'b0; in_data = '0; rd_address = '0;
    tick();
    sclr = 1'b0;
    chk("rst_start", 64'(start_comp_n), 64'd0);
    chk("rst_busy", 64'(busy_n), 64'd0);
    chk("rst_cnt", 64'(cnt_n), 64'd0);
    chk("rst_ovf", 64'(overflow_n), 64'd0);
    chk("rst_ready", 64'(in_ready_n), 64'd0);

    // IDLE ignores samples
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    chk("idle_cnt", 64'(cnt_n), 64'd0);
    chk("idle_ovf", 64'(overflow_n), 64'd0);

    // Natural-order frame
    do_arm();
    chk("arm_busy", 64'(busy_n), 64'd1);
    chk("arm_ready", 64'(in_ready_n), 64'd1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = {32'hA5A5_0000 + 32'(i), 32'h0};
      if (i == N-1) chk("nat_start_early", 64'(start_comp_n), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("nat_start", 64'(start_comp_n), 64'd1);
    chk("nat_cnt", 64'(cnt_n), 64'd32);
    chk("nat_busy", 64'(busy_n), 64'd0);
    chk("nat_ready", 64'(in_ready_n), 64'd0);
    for (int k = 0; k < N; k++) begin
      read_nat(k, d);
      chk($sformatf("nat_rd%0d", k), d, {32'hA5A5_0000 + 32'(k), 32'h0});
    end
    rd_address = 5'd16; #1;
    chk("rev_rd16_nat", rd_data_r, {32'hA5A5_0001, 32'h0});

    // Overflow while FULL
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 64'hDEAD_BEEF_DEAD_BEEF; tick();
    end
    in_valid = 1'b0;
    chk("ovf_set", 64'(overflow_n), 64'd1);
    chk("ovf_start", 64'(start_comp_n), 64'd1);
    for (int k = 0; k < N; k++) begin
      read_nat(k, d);
      chk($sformatf("ovf_rd%0d", k), d, {32'hA5A5_0000 + 32'(k), 32'h0});
    end
    do_arm();
    chk("rearm_ovf", 64'(overflow_n), 64'd0);
    chk("rearm_start", 64'(start_comp_n), 64'd0);
    chk("rearm_cnt", 64'(cnt_n), 64'd0);

    // Arm wins over a same-cycle sample
    in_valid = 1'b1; in_data = 64'd77; arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_wins_cnt", 64'(cnt_n), 64'd0);

    // Bit-reversed frame, data = index
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = 64'(i); tick();
    end
    in_valid = 1'b0;
    chk("rev_start", 64'(start_comp_r), 64'd1);
    rd_address = 5'd16; #1; chk("rev_rd16", rd_data_r, 64'd1);
    rd_address = 5'd24; #1; chk("rev_rd24", rd_data_r, 64'd3);
    rd_address = 5'd12; #1; chk("rev_rd12", rd_data_r, 64'd6);
    rd_address = 5'd31; #1; chk("rev_rd31", rd_data_r, 64'd31);
    rd_address = 5'd0;  #1; chk("rev_rd0",  rd_data_r, 64'd0);
    rd_address = 5'd1;  #1; chk("rev_rd1",  rd_data_r, 64'd16);
    read_nat(6, d); chk("nat_rd6_b", d, 64'd6);

    // Gapped input: valid on even cycles only
    do_arm();
    for (int j = 0; j < 64; j++) begin
      in_valid = (j % 2 == 0);
      in_data  = 64'(100 + j/2);
      if (j <= 62) chk($sformatf("gap_busy%0d", j), 64'(busy_n), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    chk("gap_start", 64'(start_comp_n), 64'd1);
    chk("gap_cnt", 64'(cnt_n), 64'd32);
    chk("gap_ovf", 64'(overflow_n), 64'd0);
    for (int k = 0; k < N; k += 7) begin
      read_nat(k, d);
      chk($sformatf("gap_rd%0d", k), d, 64'(100 + k));
    end

    // Reset mid-frame
    do_arm();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 64'(200 + i); tick();
    end
    in_valid = 1'b0;
    chk("mid_cnt10", 64'(cnt_n), 64'd10);
    sclr = 1'b1; tick(); sclr = 1'b0;
    chk("mid_busy", 64'(busy_n), 64'd0);
    chk("mid_cnt", 64'(cnt_n), 64'd0);
    chk("mid_ready", 64'(in_ready_n), 64'd0);
    chk("mid_start", 64'(start_comp_n), 64'd0);
    read_nat(3, d); chk("mid_ram_kept", d, 64'd203);
    do_arm();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = 64'(300 + i); tick();
    end
    in_valid = 1'b0;
    chk("mid_done_start", 64'(start_comp_n), 64'd1);
    chk("mid_done_cnt", 64'(cnt_n), 64'd32);

    // Checker integration: identical data, then one corrupted sample
    for (int i = 0; i < N; i++) ref_mem[i] = {32'hC0DE_0000 + 32'(i), 32'(i * 3)};
    do_arm();
    chk("int_start_low", 64'(start_comp_n), 64'd0);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = ref_mem[i]; tick();
    end
    in_valid = 1'b0;
    mem_check(q);
    chk("int_q_good", 64'(q), 64'd1);
    do_arm();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = (i == 7) ? (ref_mem[i] ^ 64'h1) : ref_mem[i]; tick();
    end
    in_valid = 1'b0;
    mem_check(q);
    chk("int_q_bad", 64'(q), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
